// File: rtl/button_pkg.sv
// Shared definitions for the button bank.
//   btn_state_t : per-channel press-tracking FSM encoding
//   cnt_width() : width of a counter that must hold 0..max_count (minimum 1 bit)
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // released
        ST_PRESS = 2'd1,   // held, long threshold not yet reached
        ST_LONG  = 2'd2    // held past the long threshold
    } btn_state_t;

    // A counter compared against max_count never needs to exceed it, so
    // $clog2(max_count+1) bits suffice; a zero-bit counter is not legal.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: polarity fix, 2-FF synchronizer, debounce filter,
// press-tracking FSM and one-cycle event pulses.
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   pb_in         raw asynchronous button level
//   debounced     accepted pressed level
//   press_pulse   one cycle, first cycle debounced shows pressed
//   release_pulse one cycle, first cycle debounced shows released
//   long_pulse    one cycle, LONG_CYCLES after press_pulse
//   repeat_pulse  one cycle, every REPEAT_CYCLES after long_pulse
module button_channel
    import button_pkg::*;
#(
    parameter int DEB_CYCLES    = 500000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DEB_W  = cnt_width(DEB_CYCLES - 1);
    localparam int HOLD_W = cnt_width(LONG_CYCLES - 1);
    localparam int REP_W  = cnt_width(REPEAT_CYCLES - 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic              POL_INV   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic              level_s;
    logic              sync1_r, sync2_r;
    logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_s;
    logic              deb_r, deb_s;
    logic              rise_s, fall_s;
    btn_state_t        state_r, state_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [REP_W-1:0]  rep_r, rep_s;
    logic              press_r, release_r, long_r, repeat_r;
    logic              long_s, repeat_s;

    // Everything downstream works in "1 = pressed" polarity.
    assign level_s = pb_in ^ POL_INV;

    // Debounce: count consecutive mismatch cycles; toggle on the last one.
    always_comb begin
        deb_cnt_s = deb_cnt_r;
        deb_s     = deb_r;
        rise_s    = 1'b0;
        fall_s    = 1'b0;
        if (sync2_r != deb_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_s     = ~deb_r;
                deb_cnt_s = {DEB_W{1'b0}};
                rise_s    = ~deb_r;
                fall_s    = deb_r;
            end else begin
                deb_cnt_s = deb_cnt_r + DEB_W'(1);
            end
        end else begin
            deb_cnt_s = {DEB_W{1'b0}};
        end
    end

    // Press-tracking FSM; a release always wins over long/repeat thresholds.
    always_comb begin
        state_s  = state_r;
        hold_s   = hold_r;
        rep_s    = rep_r;
        long_s   = 1'b0;
        repeat_s = 1'b0;
        if (fall_s) begin
            state_s = ST_IDLE;
            hold_s  = {HOLD_W{1'b0}};
            rep_s   = {REP_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hold_s = {HOLD_W{1'b0}};
                    rep_s  = {REP_W{1'b0}};
                    if (rise_s) begin
                        state_s = ST_PRESS;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if (hold_r == HOLD_LAST) begin
                        state_s = ST_LONG;
                        long_s  = 1'b1;
                        rep_s   = {REP_W{1'b0}};
                    end else begin
                        hold_s = hold_r + HOLD_W'(1);
                    end
                end
                ST_LONG: begin
                    if (REPEAT_EN != 0) begin
                        if (rep_r == REP_LAST) begin
                            repeat_s = 1'b1;
                            rep_s    = {REP_W{1'b0}};
                        end else begin
                            rep_s = rep_r + REP_W'(1);
                        end
                    end else begin
                        rep_s = {REP_W{1'b0}};
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    hold_s  = {HOLD_W{1'b0}};
                    rep_s   = {REP_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers; reset parks the synchronizer at "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            deb_cnt_r <= {DEB_W{1'b0}};
            deb_r     <= 1'b0;
            state_r   <= ST_IDLE;
            hold_r    <= {HOLD_W{1'b0}};
            rep_r     <= {REP_W{1'b0}};
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
        end else begin
            sync1_r   <= level_s;
            sync2_r   <= sync1_r;
            deb_cnt_r <= deb_cnt_s;
            deb_r     <= deb_s;
            state_r   <= state_s;
            hold_r    <= hold_s;
            rep_r     <= rep_s;
            press_r   <= rise_s;
            release_r <= fall_s;
            long_r    <= long_s;
            repeat_r  <= repeat_s;
        end
    end

    assign debounced     = deb_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;
    assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/button_bank.sv
// Bank of N_BTN independent debounced push-button channels.
// Ports:
//   clk, rst       system clock and synchronous active-high reset
//   pb_in          raw button levels, one bit per channel
//   debounced      accepted pressed levels
//   press_pulse, release_pulse, long_pulse, repeat_pulse
//                  one-cycle event pulses, one bit per channel
module button_bank #(
    parameter int N_BTN         = 4,
    parameter int DEB_CYCLES    = 500000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_in,
    output logic [N_BTN-1:0] debounced,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .pb_in         (pb_in[i]),
            .debounced     (debounced[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: dut_a (repeat on, active-high) and
// dut_b (repeat off, active-low) share clock and reset.
module tb_button_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pb_a = 4'h0;
    logic [3:0] pb_b = 4'hF;
    logic [3:0] deb_a, prs_a, rel_a, lng_a, rpt_a;
    logic [3:0] deb_b, prs_b, rel_b, lng_b, rpt_b;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_bank #(.N_BTN(4), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
                  .REPEAT_EN(1), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .pb_in(pb_a), .debounced(deb_a), .press_pulse(prs_a),
        .release_pulse(rel_a), .long_pulse(lng_a), .repeat_pulse(rpt_a));

    button_bank #(.N_BTN(4), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
                  .REPEAT_EN(0), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .pb_in(pb_b), .debounced(deb_b), .press_pulse(prs_b),
        .release_pulse(rel_b), .long_pulse(lng_b), .repeat_pulse(rpt_b));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] d, input logic [3:0] p,
                         input logic [3:0] r, input logic [3:0] l, input logic [3:0] rp);
        chk({tag, "/a.debounced"}, deb_a, d);
        chk({tag, "/a.press"},     prs_a, p);
        chk({tag, "/a.release"},   rel_a, r);
        chk({tag, "/a.long"},      lng_a, l);
        chk({tag, "/a.repeat"},    rpt_a, rp);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] d, input logic [3:0] p,
                         input logic [3:0] r, input logic [3:0] l, input logic [3:0] rp);
        chk({tag, "/b.debounced"}, deb_b, d);
        chk({tag, "/b.press"},     prs_b, p);
        chk({tag, "/b.release"},   rel_b, r);
        chk({tag, "/b.long"},      lng_b, l);
        chk({tag, "/b.repeat"},    rpt_b, rp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n edges with no pulses anywhere; dut_a debounced must equal da.
    task automatic quiet(input int n, input string tag, input logic [3:0] da);
        for (int k = 0; k < n; k++) begin
            step();
            chk_a(tag, da, 4'h0, 4'h0, 4'h0, 4'h0);
            chk_b(tag, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ed, ep, er, el, erp;
        int t;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk_a("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk_b("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        quiet(3, "idle", 4'h0);

        // Bounce: 3 cycles high is one short of acceptance
        pb_a[0] = 1'b1;
        quiet(3, "bounce_hi", 4'h0);
        pb_a[0] = 1'b0;
        quiet(10, "bounce_lo", 4'h0);

        // Clean press on ch1: press @6, long @26, repeat @31,36,41
        pb_a[1] = 1'b1;
        quiet(5, "p1_wait", 4'h0);
        step();
        chk_a("p1_press", 4'b0010, 4'b0010, 4'h0, 4'h0, 4'h0);
        quiet(19, "p1_hold", 4'b0010);
        step();
        chk_a("p1_long", 4'b0010, 4'h0, 4'h0, 4'b0010, 4'h0);
        quiet(4, "p1_l1", 4'b0010);
        step();
        chk_a("p1_rep1", 4'b0010, 4'h0, 4'h0, 4'h0, 4'b0010);
        quiet(4, "p1_l2", 4'b0010);
        step();
        chk_a("p1_rep2", 4'b0010, 4'h0, 4'h0, 4'h0, 4'b0010);
        quiet(4, "p1_l3", 4'b0010);
        pb_a[1] = 1'b0;   // falls @46, on top of the 4th repeat
        step();
        chk_a("p1_rep3", 4'b0010, 4'h0, 4'h0, 4'h0, 4'b0010);
        quiet(4, "p1_l4", 4'b0010);
        step();
        chk_a("p1_rel_at_rep", 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0);
        quiet(30, "p1_after", 4'h0);

        // Release on ch3 timed to land exactly on the long threshold (@26)
        pb_a[3] = 1'b1;
        quiet(5, "p3_wait", 4'h0);
        step();
        chk_a("p3_press", 4'b1000, 4'b1000, 4'h0, 4'h0, 4'h0);
        quiet(14, "p3_hold", 4'b1000);
        pb_a[3] = 1'b0;
        quiet(5, "p3_fall", 4'b1000);
        step();
        chk_a("p3_rel_at_long", 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0);
        quiet(30, "p3_idle", 4'h0);

        // Reset while ch2 is in LONG, button kept held through reset
        pb_a[2] = 1'b1;
        quiet(5, "p2_wait", 4'h0);
        step();
        chk_a("p2_press", 4'b0100, 4'b0100, 4'h0, 4'h0, 4'h0);
        quiet(19, "p2_hold", 4'b0100);
        step();
        chk_a("p2_long", 4'b0100, 4'h0, 4'h0, 4'b0100, 4'h0);
        quiet(2, "p2_inlong", 4'b0100);
        rst = 1'b1;
        quiet(2, "p2_rst", 4'h0);
        rst = 1'b0;
        quiet(5, "p2_redet", 4'h0);
        step();
        chk_a("p2_repress", 4'b0100, 4'b0100, 4'h0, 4'h0, 4'h0);
        pb_a[2] = 1'b0;
        quiet(5, "p2_fall", 4'b0100);
        step();
        chk_a("p2_release", 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0);
        quiet(5, "p2_idle", 4'h0);

        // Staggered presses on all channels of both DUTs; dut_b inverted, no repeat.
        // Channel i is sampled high on edges 2i+1..40: press @2i+6, long @2i+26,
        // repeats every 5 after that, release of all @46.
        for (int e = 1; e <= 55; e++) begin
            for (int i = 0; i < 4; i++) begin
                pb_a[i] = (e >= 2 * i + 1) && (e <= 40);
                pb_b[i] = ~pb_a[i];
            end
            step();
            for (int i = 0; i < 4; i++) begin
                t      = e - 2 * i - 26;
                ed[i]  = (e >= 2 * i + 6) && (e < 46);
                ep[i]  = (e == 2 * i + 6);
                er[i]  = (e == 46);
                el[i]  = (t == 0) && (e < 46);
                erp[i] = (t > 0) && (t % 5 == 0) && (e < 46);
            end
            chk_a("stagger", ed, ep, er, el, erp);
            chk_b("stagger", ed, ep, er, el, 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 Parameter N_BTN, default 4, number of independent button channels (>=1).
REQ-002 Parameter DEB_CYCLES, default 500000, number of consecutive stable cycles required to accept a level change (>=1).
REQ-003 Parameter LONG_CYCLES, default 50000000, number of cycles debounced-high before long_pulse fires (>=2).
REQ-004 Parameter REPEAT_CYCLES, default 10000000, auto-repeat period after a long press (>=1).
REQ-005 Parameter REPEAT_EN, default 1; when 1, auto-repeat is enabled; when 0, repeat_pulse is tied to 0.
REQ-006 Parameter ACTIVE_LOW, default 0; when 1, pb_in is inverted at the input, so a low level means pressed.
REQ-007 clk  input  1  single system clock, rising edge; the only clock in the block.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 pb_in  input  N_BTN  raw, asynchronous button levels.
REQ-010 debounced  output  N_BTN  accepted (filtered) pressed level per channel.
REQ-011 press_pulse  output  N_BTN  one-cycle pulse on an accepted press.
REQ-012 release_pulse  output  N_BTN  one-cycle pulse on an accepted release.
REQ-013 long_pulse  output  N_BTN  one-cycle pulse when a press has been held for LONG_CYCLES.
REQ-014 repeat_pulse  output  N_BTN  one-cycle pulse every REPEAT_CYCLES while the long press continues.

Function
REQ-015 Each channel SHALL be fully independent; bit i of every output depends only on pb_in[i].
REQ-016 Each channel SHALL pass pb_in (after the ACTIVE_LOW polarity fix) through a 2-FF synchronizer before any other logic.
REQ-017 The debounce counter SHALL increment each cycle while the synchronizer output differs from debounced.
REQ-018 The debounce counter SHALL clear on any cycle where the synchronizer output equals debounced, so a bounce restarts the count.
REQ-019 When the debounce counter equals DEB_CYCLES-1 and the mismatch persists, debounced SHALL toggle on that edge and the counter SHALL clear.
REQ-020 Latency: with a level held stable, debounced SHALL change on the (DEB_CYCLES+2)th rising edge counted from the first edge that samples the new level.
REQ-021 press_pulse and release_pulse SHALL be registered, and SHALL be high for exactly the one cycle in which debounced first shows the new value.
REQ-022 Per-channel FSM states: IDLE (released), PRESS (held, below long threshold), LONG (held, past long threshold).
REQ-023 FSM transition IDLE->PRESS SHALL occur on a debounced rise, clearing the hold counter.
REQ-024 In PRESS, the hold counter SHALL increment each cycle.
REQ-025 The FSM SHALL move PRESS->LONG with long_pulse high for one cycle, exactly LONG_CYCLES cycles after press_pulse.
REQ-026 In LONG with REPEAT_EN=1, repeat_pulse SHALL fire at LONG_CYCLES + k*REPEAT_CYCLES cycles after press_pulse, for k>=1.
REQ-027 The repeat counter SHALL wrap to 0 at each repeat_pulse and SHALL never overflow.
REQ-028 A debounced fall in any state SHALL send the FSM to IDLE and clear the hold and repeat counters.
REQ-029 Simultaneous events: a release that coincides with the long or repeat threshold SHALL win; only release_pulse fires.
REQ-030 At most one of the four pulse outputs SHALL be high per channel per cycle.
REQ-031 Counter widths SHALL be $clog2(max count + 1); threshold compares are exact equality, with no off-by-one slack.

Reset
REQ-032 On rst=1 at a clock edge, all outputs SHALL be 0, all counters 0, FSMs IDLE, and synchronizer flops set to the released level.
REQ-033 Reset asserted mid-press SHALL abort the press without emitting release_pulse.
REQ-034 After rst deasserts with the button still held, the press SHALL be re-detected with the full REQ-020 latency and a fresh press_pulse.

Structure
REQ-035 Shared package button_pkg SHALL hold the FSM state encoding (IDLE/PRESS/LONG) and the counter-width function.
REQ-036 Sub-module button_channel SHALL implement one channel (synchronizer, debounce, FSM, pulses).
REQ-037 button_bank SHALL instantiate N_BTN copies of button_channel through a generate loop and contain no other logic.

Verification
Bench parameters: N_BTN=4, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, REPEAT_EN=1, ACTIVE_LOW=0.
REQ-038 Bounce: pb_in[0] high for 3 cycles then low -> debounced[0] stays 0 and no pulse fires.
REQ-039 Clean press: pb_in[1] rises and is held -> debounced[1] rises on edge 6 with press_pulse[1] high that cycle only; long_pulse[1] fires 20 cycles later, and repeat_pulse[1] fires at +25, +30, +35.
REQ-040 Release at threshold: release timed so debounced falls in the cycle long_pulse would fire -> only release_pulse fires, and the FSM returns to IDLE.
REQ-041 Reset mid-press: rst pulsed while pb_in[2] is held in LONG -> all outputs 0 and no release_pulse; after reset, press_pulse[2] fires 6 edges later.
REQ-042 Independence: staggered presses on all 4 channels -> each channel's pulse timing matches its own input; with REPEAT_EN=0 and ACTIVE_LOW=1 the same scenario runs with inverted inputs and repeat_pulse stays at 0.
